cipher_rx_buffer: RTL and testbench

CIPHER_RX_BUFFER -- requirements
Module: cipher_rx_buffer

---
 rtl/cipher_rx_buffer_if.sv | 20 ++
 rtl/cipher_rx_buffer.sv | 93 +++++++++
 tb/tb_cipher_rx_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_rx_buffer_if.sv
// Receive-side bus for the cipher RX buffer.
// The master drives the encrypted byte stream and the sink-ready signal.
// The slave returns the decrypted FIFO head and the status signals.
interface cipher_rx_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          en;
  logic [7:0]    din;
  logic          clr;
  logic          rdy;
  logic          v;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic          ovf;

  modport master (output en, din, clr, rdy, input v, dout, count, ovf);
  modport slave  (input en, din, clr, rdy, output v, dout, count, ovf);
endinterface

// File: rtl/cipher_rx_buffer.sv
// Decrypting receive FIFO.
// Each incoming byte is XORed with an 8-bit LFSR keystream and stored in a
// show-ahead FIFO. The keystream advances on every accepted en, even when a
// byte is dropped, so that it stays in lock-step with the sender. clr resyncs
// the keystream to SEED and flushes the FIFO.
module cipher_rx_buffer #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  cipher_rx_buffer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_key;
  logic [7:0]    r_dout;
  logic          r_ovf;

  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [7:0]    w_key_next;
  logic [7:0]    w_byte;
  logic [AW-1:0] w_rptr_next;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_head_next;

  assign w_full       = (r_count == FULL);
  assign w_pop        = (r_count != '0) && bus.rdy && !bus.clr;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign w_wr         = bus.en && !bus.clr && (!w_full || w_pop);
  assign w_drop       = bus.en && !bus.clr && w_full && !w_pop;
  assign w_key_next   = {r_key[6:0], r_key[7] ^ r_key[5] ^ r_key[4] ^ r_key[3]};
  assign w_byte       = bus.din ^ r_key;
  assign w_rptr_next  = w_pop ? (r_rptr + AW'(1)) : r_rptr;
  assign w_count_next = r_count + CW'(w_wr) - CW'(w_pop);
  // The incoming byte becomes the new head when it lands on the next read slot.
  assign w_head_next  = (w_wr && (r_wptr == w_rptr_next)) ? w_byte : r_mem[w_rptr_next];

  // FIFO storage: written only on accepted bytes, never reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_byte;
    end
  end

  // Pointers, occupancy, keystream, overflow flag and registered head byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_key   <= SEED;
      r_ovf   <= 1'b0;
      r_dout  <= 8'h00;
    end else if (bus.clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_key   <= SEED;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.en) begin
        r_key <= w_key_next;
      end
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      // Hold the last head byte while the FIFO is empty.
      if (w_count_next != '0) begin
        r_dout <= w_head_next;
      end
    end
  end

  assign bus.v     = (r_count != '0);
  assign bus.dout  = r_dout;
  assign bus.count = r_count;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_cipher_rx_buffer.sv
// Self-checking bench for cipher_rx_buffer against a queue-based reference model.
module tb_cipher_rx_buffer;
  localparam int         DEPTH = 4;
  localparam logic [7:0] SEED  = 8'hA5;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cipher_rx_buffer_if #(.DEPTH(DEPTH)) bus();

  cipher_rx_buffer #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO is a queue of decrypted bytes.
  logic [7:0] mq [$];
  logic [7:0] mkey;
  bit         movf;

  function automatic logic [7:0] key_adv(input logic [7:0] k);
    return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
  endfunction

  task automatic model_reset();
    mq.delete();
    mkey = SEED;
    movf = 1'b0;
  endtask

  // Applies one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic drive(input bit e, input logic [7:0] d, input bit c, input bit r);
    bus.en  = e;
    bus.din = d;
    bus.clr = c;
    bus.rdy = r;
    if (c) begin
      model_reset();
    end else begin
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (e) begin
        if (mq.size() < DEPTH) mq.push_back(d ^ mkey);
        else movf = 1'b1;
        mkey = key_adv(mkey);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst     = 1'b0;
    bus.en  = 1'b0;
    bus.din = 8'h00;
    bus.clr = 1'b0;
    bus.rdy = 1'b0;
    model_reset();
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.v !== 1'b0) begin errors++; $display("FAIL reset_v: got %0b want 0", bus.v); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", bus.ovf); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h want 00", bus.dout); end
    #3;
    rst = 1'b1;
  endtask

  task automatic test_keystream();
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h4A; exp[2] = 8'h95;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 1'b0, 1'b1);
      checks++;
      if (bus.v !== 1'b1 || bus.dout !== exp[i])
        begin errors++; $display("FAIL keystream[%0d]: got v=%0b dout=%02h want v=1 dout=%02h", i, bus.v, bus.dout, exp[i]); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.v !== 1'b0) begin errors++; $display("FAIL keystream_drain: got v=%0b want 0", bus.v); end
  endtask

  task automatic test_roundtrip();
    logic [7:0] enc [2];
    enc[0] = 8'hA5; enc[1] = 8'h4A;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, enc[i], 1'b0, 1'b1);
      checks++;
      if (bus.v !== 1'b1 || bus.dout !== 8'h00)
        begin errors++; $display("FAIL roundtrip[%0d]: got v=%0b dout=%02h want v=1 dout=00", i, bus.v, bus.dout); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [7:0] d [6];
    logic [7:0] k;
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) drive(1'b1, d[i], 1'b0, 1'b0);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", bus.count); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", bus.ovf); end
    k = SEED;
    for (int i = 0; i < 4; i++) begin
      want = d[i] ^ k;
      k = key_adv(k);
      checks++;
      if (bus.v !== 1'b1 || bus.dout !== want)
        begin errors++; $display("FAIL ovf_drain[%0d]: got v=%0b dout=%02h want v=1 dout=%02h", i, bus.v, bus.dout, want); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checks++; if (bus.v !== 1'b0) begin errors++; $display("FAIL ovf_empty: got v=%0b want 0", bus.v); end
    k = key_adv(k);
    want = d[5] ^ k;
    drive(1'b1, d[5], 1'b0, 1'b0);
    checks++;
    if (bus.dout !== want || bus.ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_sixth: got dout=%02h ovf=%0b want dout=%02h ovf=1", bus.dout, bus.ovf, want); end
  endtask

  task automatic test_full_passthrough();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'($urandom), 1'b0, 1'b1);
    checks++;
    if (bus.count !== 3'd4 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL full_pass: got count=%0d ovf=%0b want count=4 ovf=0", bus.count, bus.ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.dout !== mq[0])
        begin errors++; $display("FAIL full_pass_order[%0d]: got %02h want %02h", i, bus.dout, mq[0]); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.v !== 1'b0 || bus.count !== 3'd0 || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL mid_reset: got v=%0b count=%0d ovf=%0b want 0/0/0", bus.v, bus.count, bus.ovf); end
    #1;
    rst = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.v !== 1'b1 || bus.dout !== 8'hA5 || bus.count !== 3'd1)
      begin errors++; $display("FAIL mid_reset_first: got v=%0b dout=%02h count=%0d want v=1 dout=A5 count=1", bus.v, bus.dout, bus.count); end
  endtask

  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.count !== 3'd2 || bus.ovf !== 1'b1)
      begin errors++; $display("FAIL clr_setup: got count=%0d ovf=%0b want count=2 ovf=1", bus.count, bus.ovf); end
    drive(1'b1, 8'($urandom), 1'b1, 1'b1);
    checks++;
    if (bus.count !== 3'd0 || bus.ovf !== 1'b0 || bus.v !== 1'b0)
      begin errors++; $display("FAIL clr_flush: got count=%0d ovf=%0b v=%0b want 0/0/0", bus.count, bus.ovf, bus.v); end
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.dout !== 8'hA5 || bus.count !== 3'd1)
      begin errors++; $display("FAIL clr_resync: got dout=%02h count=%0d want dout=A5 count=1", bus.dout, bus.count); end
  endtask

  task automatic test_random();
    bit e, c, r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 39) == 0);
      drive(e, 8'($urandom), c, r);
      checks++;
      if (bus.v !== (mq.size() != 0) || bus.count !== 3'(mq.size()) || bus.ovf !== movf ||
          (mq.size() != 0 && bus.dout !== mq[0]))
        begin
          errors++;
          $display("FAIL random[%0d]: got v=%0b count=%0d ovf=%0b dout=%02h want v=%0b count=%0d ovf=%0b dout=%02h",
                   i, bus.v, bus.count, bus.ovf, bus.dout, (mq.size() != 0), mq.size(), movf,
                   (mq.size() != 0) ? mq[0] : 8'h00);
        end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.din = 8'h00;
    bus.clr = 1'b0;
    bus.rdy = 1'b0;
    model_reset();
    test_reset();
    test_keystream();
    test_roundtrip();
    test_overflow();
    test_full_passthrough();
    test_reset_midstream();
    test_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end
endmodule
